regfile_mp: RTL and testbench

- Parametrised multi-port integer register file with an integrated write-pending scoreboard, for the pipelined RV32I core.
- Provides NRD combinational read ports and NWR synchronous write ports.
- Optional write-to-read bypass, so decode sees same-cycle writeback data.
- Per-register pending bits let the issue stage stall on RAW hazards.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_mp.sv | 95 +++++++++
 tb/tb_regfile_mp.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   // Widest packed bus and widest single field the extract helper handles.
   localparam int PK_MAX  = 2048;
   localparam int FLD_MAX = 64;

   // Address width for a register file of nreg entries (nreg >= 2).
   function automatic int addr_w(input int nreg);
      return (nreg < 2) ? 1 : $clog2(nreg);
   endfunction

   // Extract field k of width w from a packed bus, zero-extended to FLD_MAX.
   function automatic logic [FLD_MAX-1:0] field(input logic [PK_MAX-1:0] vec,
                                                input int k, input int w);
      logic [PK_MAX-1:0]  sh;
      logic [FLD_MAX-1:0] mask;
      sh   = vec >> (k * w);
      mask = {FLD_MAX{1'b1}} >> (FLD_MAX - w);
      return sh[FLD_MAX-1:0] & mask;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one pending bit per register.
// A reserve marks a register as having an outstanding producer; any
// enabled write to it clears the bit. Reserve beats a same-cycle write
// because the write belongs to the older instruction.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREG     = NREG_DEF,
   parameter int NWR      = 2,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW      = addr_w(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   output logic [NREG-1:0]   busy_vec
);

   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_nxt;
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;
   logic [AW-1:0]   wa [NWR];

   // Decode reserve/write requests into per-register set and clear masks.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int p = 0; p < NWR; p++) begin
         wa[p] = AW'(field(PK_MAX'(wr_addr), p, AW));
         if (wr_en[p]) clr_vec[wa[p]] = 1'b1;
      end
      if (rsv_en) set_vec[rsv_addr] = 1'b1;
      if (ZERO_REG) set_vec[0] = 1'b0;
      pend_nxt = set_vec | (pend & ~clr_vec);
   end

   // Pending bit register; reset drops any in-flight updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend <= '0;
      else     pend <= pend_nxt;
   end

   assign busy_vec = pend;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and an
// integrated RAW scoreboard for the pipelined RV32I core.
// Higher-numbered write ports win on address conflicts. Field widths are
// limited by the package extract helper (XLEN <= 64).
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW      = addr_w(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_pend,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   output logic [NREG-1:0]     busy_vec
);

   logic [XLEN-1:0] regs [NREG];
   logic [AW-1:0]   ra [NRD];
   logic [AW-1:0]   wa [NWR];
   logic [XLEN-1:0] wd [NWR];
   // Write enables as seen by the bypass path; reset must hide them.
   logic [NWR-1:0]  wr_live;

   assign wr_live = wr_en & {NWR{~rst}};

   // Unpack the flat address/data buses into per-port arrays.
   always_comb begin
      for (int k = 0; k < NRD; k++) ra[k] = AW'(field(PK_MAX'(rd_addr), k, AW));
      for (int p = 0; p < NWR; p++) begin
         wa[p] = AW'(field(PK_MAX'(wr_addr), p, AW));
         wd[p] = XLEN'(field(PK_MAX'(wr_data), p, XLEN));
      end
   end

   // Register array; ascending port loop lets the highest port win.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && !(ZERO_REG && wa[p] == '0)) regs[wa[p]] <= wd[p];
         end
      end
   end

   regfile_scoreboard #(
      .NREG     (NREG),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .busy_vec (busy_vec)
   );

   // Read muxes: array value, optional same-cycle forward, zero register.
   always_comb begin
      logic [XLEN-1:0] val;
      logic            hit;
      rd_data = '0;
      rd_pend = '0;
      for (int k = 0; k < NRD; k++) begin
         val = regs[ra[k]];
         hit = 1'b0;
         for (int p = 0; p < NWR; p++) begin
            if (wr_live[p] && wa[p] == ra[k]) begin
               hit = 1'b1;
               if (BYPASS) val = wd[p];
            end
         end
         if (ZERO_REG && ra[k] == '0) val = '0;
         rd_data[k*XLEN +: XLEN] = val;
         // A register being written this cycle has its data forwarded,
         // so with bypass it no longer needs to stall the reader.
         rd_pend[k] = busy_vec[ra[k]] & ~(BYPASS & hit);
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing instance and a
// non-bypassing instance share every input.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_pend, rd_pend_nb;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic [31:0] busy_vec, busy_nb;

   int checks = 0;
   int errors = 0;

   regfile_mp #(.BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_pend(rd_pend), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_vec(busy_vec)
   );

   regfile_mp #(.BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
      .rd_pend(rd_pend_nb), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_vec(busy_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rdv(input int k);
      return rd_data[k*32 +: 32];
   endfunction

   function automatic logic [31:0] rdv_nb(input int k);
      return rd_data_nb[k*32 +: 32];
   endfunction

   task automatic set_rd(input int k, input logic [4:0] a);
      rd_addr[k*5 +: 5] = a;
   endtask

   task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
      wr_en[p]              = 1'b1;
      wr_addr[p*5 +: 5]     = a;
      wr_data[p*32 +: 32]   = d;
   endtask

   task automatic idle();
      wr_en  = '0;
      rsv_en = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_wr(0, 5'd1, 32'h0000_0001);
      set_wr(1, 5'd2, 32'h0000_0002);
      rsv_en = 1'b1; rsv_addr = 5'd3;
      tick();
      tick();
      for (int a = 1; a < 32; a++) begin
         set_rd(0, 5'(a));
         set_rd(1, 5'(a));
         #1;
         checks++;
         if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
            errors++;
            $display("FAIL reset_read x%0d: got %h / %h, want 0", a, rd_data, rd_data_nb);
         end
      end
      checks++;
      if (busy_vec !== 32'h0 || rd_pend !== 2'b00 || busy_nb !== 32'h0) begin
         errors++;
         $display("FAIL reset_busy: got busy %h pend %b, want 0", busy_vec, rd_pend);
      end
      idle();
      rst = 1'b0;
      tick();
      set_wr(0, 5'd5, 32'hDEAD_BEEF);
      tick();
      idle();
      set_rd(0, 5'd5);
      #1;
      checks++;
      if (rdv(0) !== 32'hDEAD_BEEF || rdv_nb(0) !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL first_write x5: got %h / %h, want deadbeef", rdv(0), rdv_nb(0));
      end
   endtask

   task automatic test_dual_write();
      set_wr(0, 5'd7, 32'h1111_1111);
      set_wr(1, 5'd7, 32'h2222_2222);
      tick();
      idle();
      set_rd(0, 5'd7);
      #1;
      checks++;
      if (rdv(0) !== 32'h2222_2222 || rdv_nb(0) !== 32'h2222_2222) begin
         errors++;
         $display("FAIL dual_conflict x7: got %h / %h, want 22222222", rdv(0), rdv_nb(0));
      end
      set_wr(0, 5'd3, 32'h0000_0033);
      set_wr(1, 5'd4, 32'h0000_0044);
      tick();
      idle();
      set_rd(0, 5'd3);
      set_rd(1, 5'd4);
      #1;
      checks++;
      if (rdv(0) !== 32'h33 || rdv(1) !== 32'h44) begin
         errors++;
         $display("FAIL dual_distinct x3/x4: got %h %h, want 33 44", rdv(0), rdv(1));
      end
   endtask

   task automatic test_bypass();
      set_rd(0, 5'd9);
      set_rd(1, 5'd7);
      set_wr(0, 5'd9, 32'hCAFE_0001);
      #1;
      checks++;
      if (rdv(0) !== 32'hCAFE_0001) begin
         errors++;
         $display("FAIL bypass_same_cycle: got %h, want cafe0001", rdv(0));
      end
      checks++;
      if (rdv_nb(0) !== 32'h0) begin
         errors++;
         $display("FAIL nobypass_old: got %h, want 0", rdv_nb(0));
      end
      checks++;
      if (rdv(1) !== 32'h2222_2222) begin
         errors++;
         $display("FAIL bypass_other_port: got %h, want 22222222", rdv(1));
      end
      tick();
      idle();
      #1;
      checks++;
      if (rdv_nb(0) !== 32'hCAFE_0001) begin
         errors++;
         $display("FAIL nobypass_next: got %h, want cafe0001", rdv_nb(0));
      end
      set_wr(0, 5'd9, 32'hAAAA_0000);
      set_wr(1, 5'd9, 32'hBBBB_0000);
      #1;
      checks++;
      if (rdv(0) !== 32'hBBBB_0000 || rdv_nb(0) !== 32'hCAFE_0001) begin
         errors++;
         $display("FAIL bypass_priority: got %h / %h, want bbbb0000 / cafe0001", rdv(0), rdv_nb(0));
      end
      tick();
      idle();
   endtask

   task automatic test_zero();
      set_rd(0, 5'd0);
      set_rd(1, 5'd0);
      set_wr(1, 5'd0, 32'hFFFF_FFFF);
      rsv_en = 1'b1; rsv_addr = 5'd0;
      #1;
      checks++;
      if (rd_data !== 64'h0) begin
         errors++;
         $display("FAIL zero_bypass: got %h, want 0", rd_data);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_data_nb !== 64'h0 || busy_vec[0] !== 1'b0 || rd_pend !== 2'b00) begin
         errors++;
         $display("FAIL zero_reg: got data %h busy0 %b pend %b, want 0", rd_data, busy_vec[0], rd_pend);
      end
   endtask

   task automatic test_scoreboard();
      set_rd(0, 5'd12);
      set_rd(1, 5'd13);
      rsv_en = 1'b1; rsv_addr = 5'd12;
      #1;
      checks++;
      if (rd_pend !== 2'b00) begin
         errors++;
         $display("FAIL rsv_not_visible: got %b, want 00", rd_pend);
      end
      tick();
      idle();
      #1;
      checks++;
      if (busy_vec !== 32'h0000_1000 || rd_pend[0] !== 1'b1 || rd_pend_nb[0] !== 1'b1) begin
         errors++;
         $display("FAIL rsv_x12: got busy %h pend %b, want 00001000 1", busy_vec, rd_pend[0]);
      end
      set_wr(0, 5'd12, 32'h0000_0C0C);
      rsv_en = 1'b1; rsv_addr = 5'd12;
      #1;
      checks++;
      if (rd_pend[0] !== 1'b0 || rd_pend_nb[0] !== 1'b1) begin
         errors++;
         $display("FAIL wr_rsv_pend_read: got %b / %b, want 0 / 1", rd_pend[0], rd_pend_nb[0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (busy_vec !== 32'h0000_1000 || rdv(0) !== 32'h0000_0C0C) begin
         errors++;
         $display("FAIL rsv_wins: got busy %h data %h, want 00001000 00000c0c", busy_vec, rdv(0));
      end
      set_wr(1, 5'd12, 32'h0000_1212);
      #1;
      checks++;
      if (rd_pend[0] !== 1'b0 || rd_pend_nb[0] !== 1'b1) begin
         errors++;
         $display("FAIL clear_pend_read: got %b / %b, want 0 / 1", rd_pend[0], rd_pend_nb[0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (busy_vec !== 32'h0 || busy_nb !== 32'h0 || rd_pend !== 2'b00) begin
         errors++;
         $display("FAIL write_clears: got busy %h pend %b, want 0 00", busy_vec, rd_pend);
      end
      rsv_en = 1'b1; rsv_addr = 5'd13;
      tick();
      tick();
      idle();
      set_wr(0, 5'd13, 32'h0000_1313);
      tick();
      idle();
      #1;
      checks++;
      if (busy_vec !== 32'h0 || rdv(1) !== 32'h0000_1313) begin
         errors++;
         $display("FAIL no_counting x13: got busy %h data %h, want 0 00001313", busy_vec, rdv(1));
      end
   endtask

   task automatic test_async_reset();
      set_wr(0, 5'd2, 32'h0000_0005);
      rsv_en = 1'b1; rsv_addr = 5'd2;
      tick();
      idle();
      set_rd(0, 5'd2);
      #1;
      checks++;
      if (rdv(0) !== 32'h5 || busy_vec !== 32'h0000_0004) begin
         errors++;
         $display("FAIL pre_reset x2: got %h busy %h, want 5 00000004", rdv(0), busy_vec);
      end
      set_wr(0, 5'd2, 32'h0000_0007);
      rsv_en = 1'b1; rsv_addr = 5'd2;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rdv(0) !== 32'h0 || rdv_nb(0) !== 32'h0 || busy_vec !== 32'h0 || busy_nb !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: got %h / %h busy %h, want 0", rdv(0), rdv_nb(0), busy_vec);
      end
      #1;
      idle();
      rst = 1'b0;
      tick();
      checks++;
      if (rdv(0) !== 32'h0 || busy_vec !== 32'h0) begin
         errors++;
         $display("FAIL after_reset: got %h busy %h, want 0", rdv(0), busy_vec);
      end
   endtask

   initial begin
      rst      = 1'b1;
      rd_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      test_reset();
      test_dual_write();
      test_bypass();
      test_zero();
      test_scoreboard();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
